// File: rtl/reg_ctx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_ctx_pkg
//  Description : Shared types and constants for the register context mover:
//                FSM state enum, transfer-direction encodings and the
//                register-file address/data widths.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_ctx_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // Transfer direction, sampled together with start
  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_RESTORE = 3'd2,
    ST_CSUM    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/reg_ctx_mover.sv
`default_nettype none
// ============================================================================
//  Module      : reg_ctx_mover
//  Description : Moves registers FIRST_REG..LAST_REG between a register file
//                and a valid/ready word stream.
//                  SAVE    : regfile -> out stream (out_valid/out_ready/out_data)
//                  RESTORE : in stream -> regfile  (in_valid/in_ready/in_data)
//                Optional feature macro REG_CTX_CHECKSUM_EN appends an XOR
//                checksum word to each transfer; on RESTORE a mismatching
//                checksum raises the sticky err flag.
//  Ports       : clk, rst_n (async, active-low)
//                start/mode/abort        - transfer control
//                busy/done/err           - status
//                rf_addr/rf_rdata        - regfile read port (comb. read)
//                rf_rw/rf_waddr/rf_wdata - regfile write port
//                out_valid/out_ready/out_data, in_valid/in_ready/in_data
//  Revision    : 1.0  initial release
// ============================================================================
module reg_ctx_mover
  import reg_ctx_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [REG_AW-1:0] rf_addr,
  input  logic [REG_DW-1:0] rf_rdata,
  output logic              rf_rw,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_DW-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_DW-1:0] in_data
);

  localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

  // Where the data phase goes once the last register has been handshaken
`ifdef REG_CTX_CHECKSUM_EN
  localparam state_e SAVE_END    = ST_CSUM;
  localparam state_e RESTORE_END = ST_CHECK;
`else
  localparam state_e SAVE_END    = ST_DONE;
  localparam state_e RESTORE_END = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic              last_idx;

`ifdef REG_CTX_CHECKSUM_EN
  logic [REG_DW-1:0] csum_q, csum_d;
  logic              err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign last_idx = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
`ifdef REG_CTX_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;
    rf_addr   = '0;
    rf_rw     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        // abort outranks start even while idle
        if (start && !abort) begin
          idx_d   = FIRST_IDX;
`ifdef REG_CTX_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
          state_d = (mode == MODE_RESTORE) ? ST_RESTORE : ST_SAVE;
        end
      end

      ST_SAVE: begin
        busy     = 1'b1;
        rf_addr  = idx_q;
        // idx only moves on a handshake, so out_data is stable while stalled
        out_data = rf_rdata;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
`ifdef REG_CTX_CHECKSUM_EN
            csum_d = csum_q ^ rf_rdata;
`endif
            if (last_idx) state_d = SAVE_END;
            else          idx_d   = idx_q + 5'd1;
          end
        end
      end

      ST_RESTORE: begin
        busy     = 1'b1;
        rf_waddr = idx_q;
        rf_wdata = in_data;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            rf_rw = 1'b1;
`ifdef REG_CTX_CHECKSUM_EN
            csum_d = csum_q ^ in_data;
`endif
            if (last_idx) state_d = RESTORE_END;
            else          idx_d   = idx_q + 5'd1;
          end
        end
      end

`ifdef REG_CTX_CHECKSUM_EN
      ST_CSUM: begin
        busy     = 1'b1;
        out_data = csum_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) state_d = ST_DONE;
        end
      end

      ST_CHECK: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          in_ready = 1'b1;
          // checksum word is compared only, never written to the regfile
          if (in_valid) begin
            if (in_data != csum_q) err_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST_IDX;
`ifdef REG_CTX_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef REG_CTX_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire
